// File: rtl/conv3x3_filter.sv
// 3x3 video convolution filter: passthrough, box, gaussian, sobel and sharpen on each colour
// channel. Two line buffers feed a sliding window; the pipeline has three stages and the syncs are delayed to match.
module conv3x3_filter #(
  parameter int CH_WIDTH  = 8,
  parameter int NUM_CH    = 3,
  parameter int MAX_WIDTH = 2048,
  localparam int DATA_WIDTH = CH_WIDTH * NUM_CH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  input  logic [2:0]            i_mode,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic [2:0]            o_mode
);
  localparam int XW   = (MAX_WIDTH > 2) ? $clog2(MAX_WIDTH) : 2;
  localparam int YW   = 12;
  localparam int ACCW = CH_WIDTH + 6;
  localparam int PW   = ACCW + 7;
  localparam logic [XW-1:0] XMAX = XW'(MAX_WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_BOX   = 3'd1,
    MODE_GAUSS = 3'd2,
    MODE_SOBEL = 3'd3,
    MODE_SHARP = 3'd4
  } mode_e;
  typedef logic signed [ACCW-1:0] acc_t;

  localparam acc_t CH_MAX = acc_t'((1 << CH_WIDTH) - 1);

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  ovf_q, ovf_d;
  logic                  lineOk_q, lineOk_d;
  logic                  vdePrev_q, vsPrev_q;
  mode_e                 mode_q, mode_d, mode2_q;
  logic [2:0]            hsDly_q, vsDly_q, vdeDly_q;
  logic                  s1Valid_q, s2Valid_q;
  logic [DATA_WIDTH-1:0] win_q [3][3];
  logic [DATA_WIDTH-1:0] lb1 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] lbRd1, lbRd2;
  logic                  vdeFall, vsRise, lbWe, pixValid;

  // lineOk_q is only set once blanking has been seen, so a line cut short by reset never counts as a row.
  always_comb begin
    vdeFall  = vdePrev_q & ~i_vid_VDE;
    vsRise   = i_vid_vsync & ~vsPrev_q;
    lbWe     = i_vid_VDE & ~ovf_q;
    pixValid = lbWe && (x_q >= XW'(2)) && (y_q >= YW'(2));
    lbRd1    = lb1[x_q];
    lbRd2    = lb2[x_q];
    x_d      = x_q;
    ovf_d    = ovf_q;
    y_d      = y_q;
    lineOk_d = lineOk_q | ~i_vid_VDE;
    mode_d   = mode_q;
    if (vdeFall) begin
      x_d   = '0;
      ovf_d = 1'b0;
    end else if (i_vid_VDE) begin
      if (x_q == XMAX) ovf_d = 1'b1;
      else             x_d   = x_q + 1'b1;
    end
    if (vsRise)                                  y_d = '0;
    else if (vdeFall && lineOk_q && y_q != '1)   y_d = y_q + 1'b1;
    if (vsRise) mode_d = (i_mode > 3'd4) ? MODE_PASS : mode_e'(i_mode);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      lineOk_q  <= 1'b0;
      vdePrev_q <= 1'b0;
      vsPrev_q  <= 1'b0;
      mode_q    <= MODE_PASS;
      mode2_q   <= MODE_PASS;
      hsDly_q   <= '0;
      vsDly_q   <= '0;
      vdeDly_q  <= '0;
      s1Valid_q <= 1'b0;
      s2Valid_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      lineOk_q  <= lineOk_d;
      vdePrev_q <= i_vid_VDE;
      vsPrev_q  <= i_vid_vsync;
      mode_q    <= mode_d;
      mode2_q   <= mode_q;
      hsDly_q   <= {hsDly_q[1:0], i_vid_hsync};
      vsDly_q   <= {vsDly_q[1:0], i_vid_vsync};
      vdeDly_q  <= {vdeDly_q[1:0], i_vid_VDE};
      s1Valid_q <= pixValid;
      s2Valid_q <= s1Valid_q;
      if (i_vid_VDE) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lbRd2;
        win_q[1][2] <= lbRd1;
        win_q[2][2] <= i_vid_data;
      end
    end
  end

  // Line buffers are deliberately not reset; the border mask hides stale rows.
  always_ff @(posedge clk) begin
    if (lbWe) begin
      lb1[x_q] <= i_vid_data;
      lb2[x_q] <= lbRd1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    acc_t                p [3][3];
    acc_t                a_d, b_d, a_q, b_q;
    acc_t                absA, absB, mag;
    logic [PW-1:0]       boxProd;
    logic [CH_WIDTH-1:0] res_d, res_q;

    always_comb begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          p[r][c] = acc_t'({1'b0, win_q[r][c][k*CH_WIDTH +: CH_WIDTH]});
      a_d = p[1][1];
      b_d = '0;
      case (mode_q)
        MODE_BOX:   a_d = p[0][0] + p[0][1] + p[0][2] + p[1][0] + p[1][1] + p[1][2]
                        + p[2][0] + p[2][1] + p[2][2];
        MODE_GAUSS: a_d = p[0][0] + (p[0][1] <<< 1) + p[0][2]
                        + (p[1][0] <<< 1) + (p[1][1] <<< 2) + (p[1][2] <<< 1)
                        + p[2][0] + (p[2][1] <<< 1) + p[2][2];
        MODE_SOBEL: begin
          a_d = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
          b_d = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
        end
        MODE_SHARP: a_d = (p[1][1] <<< 2) + p[1][1] - (p[0][1] + p[2][1] + p[1][0] + p[1][2]);
        default:    ;
      endcase
    end

    always_comb begin
      absA    = a_q[ACCW-1] ? -a_q : a_q;
      absB    = b_q[ACCW-1] ? -b_q : b_q;
      mag     = absA + absB;
      boxProd = PW'($unsigned(a_q)) * PW'(57);
      res_d   = '0;
      if (s2Valid_q) begin
        case (mode2_q)
          MODE_BOX:   res_d = CH_WIDTH'(boxProd >> 9);
          MODE_GAUSS: res_d = CH_WIDTH'(a_q >>> 4);
          MODE_SOBEL: res_d = (mag > CH_MAX) ? '1 : CH_WIDTH'(mag);
          MODE_SHARP: res_d = a_q[ACCW-1] ? '0 : ((a_q > CH_MAX) ? '1 : CH_WIDTH'(a_q));
          default:    res_d = CH_WIDTH'(a_q);
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q   <= '0;
        b_q   <= '0;
        res_q <= '0;
      end else begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
      end
    end

    assign o_vid_data[k*CH_WIDTH +: CH_WIDTH] = res_q;
  end

  assign o_vid_hsync = hsDly_q[2];
  assign o_vid_vsync = vsDly_q[2];
  assign o_vid_VDE   = vdeDly_q[2];
  assign o_mode      = mode_q;
endmodule
